// File: rtl/rmii_receive_deframer_pkg.sv
// Shared types and constants for the RMII receive path and the transmit framer.
package switch_package;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        PREAMBLE  = 2'd2,
        DATA      = 2'd3
    } deframer_state_t;

    localparam logic [31:0] CRC32_POLY_REFLECTED = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT           = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE        = 32'hDEBB20E3;

    localparam logic [1:0]  RMII_PREAMBLE_DIBIT  = 2'b01;
    localparam logic [1:0]  RMII_SFD_DIBIT       = 2'b11;

endpackage

// File: rtl/rmii_receive_deframer_crc32.sv
// Combinational Ethernet CRC-32 advance by one byte, LSB first, reflected polynomial.
module ethernet_crc32_byte
    import switch_package::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_s;

    // Eight serial CRC steps unrolled into one byte-wide update
    always_comb begin
        crc_s = crc_i ^ {24'd0, data_i};
        for (int i = 0; i < 8; i++) begin
            if (crc_s[0]) begin
                crc_s = (crc_s >> 1) ^ CRC32_POLY_REFLECTED;
            end else begin
                crc_s = crc_s >> 1;
            end
        end
        crc_o = crc_s;
    end

endmodule

// File: rtl/rmii_receive_deframer.sv
// RMII receive deframer: preamble/SFD hunt, dibit-to-byte assembly, CRC/length checks.
module rmii_receive_deframer
    import switch_package::*;
#(
    parameter int MIN_FRAME_BYTES     = 64,
    parameter int MAX_FRAME_BYTES     = 1522,
    parameter int MIN_PREAMBLE_DIBITS = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] rmii_receive_data,
    input  logic       rmii_receive_data_enable,
    input  logic       rmii_receive_data_error,
    output logic [8:0] receive_data,
    output logic       receive_data_valid,
    output logic       frame_status_valid,
    output logic       frame_good
);

    localparam logic [3:0]  MIN_PRE_CNT = 4'(MIN_PREAMBLE_DIBITS);
    localparam logic [10:0] MIN_LEN     = 11'(MIN_FRAME_BYTES);
    localparam logic [10:0] MAX_LEN     = 11'(MAX_FRAME_BYTES);

    deframer_state_t state_q, state_d;
    logic [3:0]  pre_cnt_q, pre_cnt_d;
    logic [7:0]  byte_q, byte_d;
    logic [1:0]  dib_cnt_q, dib_cnt_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  held_q, held_d;
    logic        held_valid_q, held_valid_d;
    logic        err_q, err_d;
    logic [8:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        status_q, status_d;
    logic        good_q, good_d;

    logic [7:0]  complete_byte_s;
    logic [31:0] crc_next_s;

    assign complete_byte_s = {rmii_receive_data, byte_q[7:2]};

    ethernet_crc32_byte u_crc (
        .crc_i  (crc_q),
        .data_i (complete_byte_s),
        .crc_o  (crc_next_s)
    );

    // Next-state logic; one byte is held back so the final byte can carry the last flag
    always_comb begin
        state_d      = state_q;
        pre_cnt_d    = pre_cnt_q;
        byte_d       = byte_q;
        dib_cnt_d    = dib_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        crc_d        = crc_q;
        held_d       = held_q;
        held_valid_d = held_valid_q;
        err_d        = err_q;
        data_d       = 9'd0;
        valid_d      = 1'b0;
        status_d     = 1'b0;
        good_d       = 1'b0;
        case (state_q)
            WAIT_IDLE: begin
                if (!rmii_receive_data_enable) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_IDLE;
                end
            end
            IDLE: begin
                if (rmii_receive_data_enable && (rmii_receive_data == RMII_PREAMBLE_DIBIT)) begin
                    state_d   = PREAMBLE;
                    pre_cnt_d = 4'd1;
                end else begin
                    state_d   = IDLE;
                end
            end
            PREAMBLE: begin
                if (!rmii_receive_data_enable) begin
                    state_d = IDLE;
                end else if (rmii_receive_data == RMII_PREAMBLE_DIBIT) begin
                    if (pre_cnt_q != 4'hF) begin
                        pre_cnt_d = pre_cnt_q + 4'd1;
                    end else begin
                        pre_cnt_d = pre_cnt_q;
                    end
                end else if ((rmii_receive_data == RMII_SFD_DIBIT) && (pre_cnt_q >= MIN_PRE_CNT)) begin
                    state_d = DATA;
                end else begin
                    state_d = WAIT_IDLE;
                end
            end
            DATA: begin
                if (!rmii_receive_data_enable) begin
                    if (held_valid_q) begin
                        data_d   = {1'b1, held_q};
                        valid_d  = 1'b1;
                        status_d = 1'b1;
                        good_d   = (crc_q == CRC32_RESIDUE) && (byte_cnt_q >= MIN_LEN) &&
                                   (byte_cnt_q <= MAX_LEN) && (dib_cnt_q == 2'd0) && !err_q;
                    end else begin
                        valid_d  = 1'b0;
                    end
                    state_d      = IDLE;
                    pre_cnt_d    = 4'd0;
                    byte_d       = 8'd0;
                    dib_cnt_d    = 2'd0;
                    byte_cnt_d   = 11'd0;
                    crc_d        = CRC32_INIT;
                    held_d       = 8'd0;
                    held_valid_d = 1'b0;
                    err_d        = 1'b0;
                end else begin
                    byte_d    = complete_byte_s;
                    dib_cnt_d = dib_cnt_q + 2'd1;
                    if (rmii_receive_data_error) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    if (dib_cnt_q == 2'd3) begin
                        crc_d = crc_next_s;
                        if (byte_cnt_q != 11'h7FF) begin
                            byte_cnt_d = byte_cnt_q + 11'd1;
                        end else begin
                            byte_cnt_d = byte_cnt_q;
                        end
                        if (held_valid_q) begin
                            data_d  = {1'b0, held_q};
                            valid_d = 1'b1;
                        end else begin
                            valid_d = 1'b0;
                        end
                        held_d       = complete_byte_s;
                        held_valid_d = 1'b1;
                    end else begin
                        crc_d = crc_q;
                    end
                end
            end
            default: begin
                state_d = WAIT_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= WAIT_IDLE;
            pre_cnt_q    <= 4'd0;
            byte_q       <= 8'd0;
            dib_cnt_q    <= 2'd0;
            byte_cnt_q   <= 11'd0;
            crc_q        <= CRC32_INIT;
            held_q       <= 8'd0;
            held_valid_q <= 1'b0;
            err_q        <= 1'b0;
            data_q       <= 9'd0;
            valid_q      <= 1'b0;
            status_q     <= 1'b0;
            good_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_cnt_q    <= pre_cnt_d;
            byte_q       <= byte_d;
            dib_cnt_q    <= dib_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            crc_q        <= crc_d;
            held_q       <= held_d;
            held_valid_q <= held_valid_d;
            err_q        <= err_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            status_q     <= status_d;
            good_q       <= good_d;
        end
    end

    assign receive_data       = data_q;
    assign receive_data_valid = valid_q;
    assign frame_status_valid = status_q;
    assign frame_good         = good_q;

endmodule

// File: tb/tb_rmii_receive_deframer.sv
// Directed and randomized frames against a byte-level model of the deframer rules.
module tb_rmii_receive_deframer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [1:0] rxd;
    logic       crs_dv;
    logic       rx_er;
    logic [8:0] receive_data;
    logic       receive_data_valid;
    logic       frame_status_valid;
    logic       frame_good;

    int errors = 0;
    int checks = 0;

    logic [8:0] got_q[$];
    logic [1:0] stat_q[$];
    logic [7:0] frm[$];

    rmii_receive_deframer dut (
        .clock                    (clock),
        .reset_n                  (reset_n),
        .rmii_receive_data        (rxd),
        .rmii_receive_data_enable (crs_dv),
        .rmii_receive_data_error  (rx_er),
        .receive_data             (receive_data),
        .receive_data_valid       (receive_data_valid),
        .frame_status_valid       (frame_status_valid),
        .frame_good               (frame_good)
    );

    always #10 clock = ~clock;

    // Capture every strobe away from the active edge
    always @(negedge clock) begin
        if (receive_data_valid) got_q.push_back(receive_data);
        if (frame_status_valid) stat_q.push_back({receive_data_valid & receive_data[8], frame_good});
    end

    // Bit-serial Ethernet CRC over the first n bytes of the frame
    function automatic logic [31:0] crc_of(int n);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ frm[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return c;
    endfunction

    function automatic bit fcs_ok();
        int n;
        n = frm.size();
        return {frm[n-1], frm[n-2], frm[n-3], frm[n-4]} == ~crc_of(n - 4);
    endfunction

    task automatic build(int n_total, bit counting);
        logic [31:0] fcs;
        frm.delete();
        for (int i = 0; i < n_total - 4; i++) frm.push_back(counting ? 8'(i) : 8'($urandom));
        fcs = ~crc_of(n_total - 4);
        frm.push_back(fcs[7:0]);
        frm.push_back(fcs[15:8]);
        frm.push_back(fcs[23:16]);
        frm.push_back(fcs[31:24]);
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic dib(logic [1:0] d, logic en, logic er);
        rxd    = d;
        crs_dv = en;
        rx_er  = er;
        @(posedge clock);
        #1;
    endtask

    task automatic outputs_zero(string tag);
        chk({tag, "_data"},   32'(receive_data), 32'd0);
        chk({tag, "_valid"},  32'(receive_data_valid), 32'd0);
        chk({tag, "_status"}, 32'(frame_status_valid), 32'd0);
        chk({tag, "_good"},   32'(frame_good), 32'd0);
    endtask

    // Drive one frame and compare against what the deframer rules predict
    task automatic run(string tag, int npre, int er_byte, int rst_byte, bit extra);
        logic [7:0] b;
        int         n_exp;
        int         first_bad;
        bit         with_status;
        bit         exp_good;
        logic [8:0] exp_word;
        got_q.delete();
        stat_q.delete();
        for (int i = 0; i < npre; i++) dib(2'b01, 1'b1, 1'b0);
        dib(2'b11, 1'b1, 1'b0);
        for (int i = 0; i < frm.size(); i++) begin
            b = frm[i];
            for (int k = 0; k < 4; k++) begin
                if (i == rst_byte && k == 0) begin
                    reset_n = 1'b0;
                    dib(b[2*k +: 2], 1'b1, 1'b0);
                    reset_n = 1'b1;
                    outputs_zero({tag, "_rst"});
                end else begin
                    dib(b[2*k +: 2], 1'b1, (i == er_byte && k == 0) ? 1'b1 : 1'b0);
                end
            end
        end
        if (extra) dib(2'b10, 1'b1, 1'b0);
        repeat (12) dib(2'b00, 1'b0, 1'b0);

        if (npre < 4) begin
            n_exp = 0;
            with_status = 1'b0;
        end else if (rst_byte >= 0) begin
            n_exp = rst_byte - 1;
            with_status = 1'b0;
        end else begin
            n_exp = frm.size();
            with_status = 1'b1;
        end
        exp_good = fcs_ok() && frm.size() >= 64 && frm.size() <= 1522 && !extra && er_byte < 0;

        chk({tag, "_count"}, 32'(got_q.size()), 32'(n_exp));
        first_bad = -1;
        for (int i = 0; i < n_exp && i < got_q.size(); i++) begin
            exp_word = {(with_status && i == n_exp - 1) ? 1'b1 : 1'b0, frm[i]};
            if (first_bad < 0 && got_q[i] !== exp_word) first_bad = i;
        end
        chk({tag, "_first_bad_byte"}, 32'(first_bad), 32'hFFFFFFFF);
        chk({tag, "_status_count"}, 32'(stat_q.size()), with_status ? 32'd1 : 32'd0);
        if (with_status && stat_q.size() == 1) begin
            chk({tag, "_status_with_last"}, 32'(stat_q[0][1]), 32'd1);
            chk({tag, "_good"}, 32'(stat_q[0][0]), 32'(exp_good));
        end
    endtask

    initial begin
        reset_n = 1'b0;
        rxd     = 2'b00;
        crs_dv  = 1'b0;
        rx_er   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        outputs_zero("reset");
        reset_n = 1'b1;
        repeat (4) dib(2'b00, 1'b0, 1'b0);

        build(64, 1'b1);
        run("t1_good", 31, -1, -1, 1'b0);

        build(64, 1'b1);
        frm[10] = frm[10] ^ 8'h04;
        run("t2_bitflip", 31, -1, -1, 1'b0);

        build(40, 1'b0);
        run("t3_runt", 31, -1, -1, 1'b0);
        build(1523, 1'b0);
        run("t3_long", 31, -1, -1, 1'b0);
        build(1522, 1'b0);
        run("max_len", 31, -1, -1, 1'b0);

        build(64, 1'b0);
        run("t4_extra_dibit", 31, -1, -1, 1'b1);

        build(80, 1'b0);
        run("t5_rx_er", 31, 20, -1, 1'b0);
        build(64, 1'b0);
        run("t5_short_pre", 3, -1, -1, 1'b0);
        build(64, 1'b0);
        run("min_pre", 4, -1, -1, 1'b0);

        build(100, 1'b0);
        run("t6_reset", 31, -1, 30, 1'b0);
        build(64 + int'($urandom_range(0, 100)), 1'b0);
        run("t6_after_reset", 31, -1, -1, 1'b0);

        for (int r = 0; r < 3; r++) begin
            build(int'($urandom_range(64, 300)), 1'b0);
            run($sformatf("rand%0d", r), int'($urandom_range(4, 31)), -1, -1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
